// File: rtl/sensor_window_buffer_if.sv
// Byte-stream handshake between an RS232 receiver (master) and the window buffer (slave).
interface sensor_window_buffer_if;
  logic       i_byte_valid;
  logic [7:0] i_byte;
  logic       o_byte_ready;

  modport master (output i_byte_valid, output i_byte, input o_byte_ready);
  modport slave  (input i_byte_valid, input i_byte, output o_byte_ready);
endinterface

// File: rtl/sensor_window_buffer.sv
// Pairs received bytes into 16-bit samples, keeps a sliding window of WIN_LEN samples
// and signals a fresh window to the downstream core every STRIDE samples once filled.
module sensor_window_buffer #(
  parameter int unsigned WIN_LEN = 40,
  parameter int unsigned STRIDE  = 8
) (
  input  logic                     avm_clk,
  input  logic                     avm_rst,
  input  logic                     i_start,
  input  logic                     i_core_busy,
  sensor_window_buffer_if.slave    byte_if,
  output logic [16*WIN_LEN-1:0]    o_window,
  output logic                     o_next,
  output logic                     o_filled,
  output logic                     o_overrun
);

  localparam int unsigned WW = 16 * WIN_LEN;
  localparam int unsigned SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] window_q, window_d;
  logic [7:0]    hi_q, hi_d;
  logic          phase_q, phase_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [SW-1:0] stride_q, stride_d;
  logic          next_q, next_d;
  logic          filled_q, filled_d;
  logic          overrun_q, overrun_d;

  logic accept;
  logic win_event;

  assign byte_if.o_byte_ready = (state_q != StIdle);
  // Start wins over a same-cycle byte, so the byte is simply never accepted.
  assign accept = byte_if.i_byte_valid && byte_if.o_byte_ready && !i_start;

  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    hi_d      = hi_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    stride_d  = stride_q;
    filled_d  = filled_q;
    overrun_d = overrun_q;
    next_d    = 1'b0;
    win_event = 1'b0;

    if (i_start) begin
      state_d   = StFill;
      window_d  = '0;
      hi_d      = '0;
      phase_d   = 1'b0;
      cnt_d     = '0;
      stride_d  = '0;
      filled_d  = 1'b0;
      overrun_d = 1'b0;
    end else if (accept) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hi_d = byte_if.i_byte;
      end else begin
        // Oldest sample sits in the top bits, so the new one enters at the bottom.
        window_d = {window_q[WW-17:0], hi_q, byte_if.i_byte};
        if (state_q == StFill) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(WIN_LEN - 1)) begin
            state_d   = StRun;
            filled_d  = 1'b1;
            stride_d  = '0;
            win_event = 1'b1;
          end
        end else begin
          if (stride_q == SW'(STRIDE - 1)) begin
            stride_d  = '0;
            win_event = 1'b1;
          end else begin
            stride_d = stride_q + SW'(1);
          end
        end
      end
    end

    if (win_event) begin
      next_d    = !i_core_busy;
      overrun_d = overrun_q | i_core_busy;
    end
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state_q   <= StIdle;
      window_q  <= '0;
      hi_q      <= '0;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      stride_q  <= '0;
      next_q    <= 1'b0;
      filled_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      hi_q      <= hi_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      stride_q  <= stride_d;
      next_q    <= next_d;
      filled_q  <= filled_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_window  = window_q;
  assign o_next    = next_q;
  assign o_filled  = filled_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_sensor_window_buffer.sv
// Bench for sensor_window_buffer: directed scenarios plus random traffic, compared each cycle
// against a sample-stream model (window = last WIN_LEN samples since start).
module tb_sensor_window_buffer;
  localparam int unsigned WL = 40;
  localparam int unsigned ST = 8;
  localparam int unsigned WW = 16 * WL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy = 1'b0;
  logic [WW-1:0] window;
  logic          nxt, filled, overrun;

  sensor_window_buffer_if bif ();

  sensor_window_buffer #(.WIN_LEN(WL), .STRIDE(ST)) dut (
    .avm_clk     (clk),
    .avm_rst     (rst),
    .i_start     (start),
    .i_core_busy (busy),
    .byte_if     (bif),
    .o_window    (window),
    .o_next      (nxt),
    .o_filled    (filled),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int next_seen = 0;

  // Reference model state
  bit          m_started;
  bit          m_phase;
  bit   [7:0]  m_held;
  logic [15:0] m_samples[$];
  bit          m_overrun;
  bit          m_next;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] model_window();
    logic [WW-1:0] w = '0;
    int n = m_samples.size();
    for (int i = 0; i < int'(WL); i++) begin
      int idx = n - int'(WL) + i;
      if (idx >= 0) w[16*(WL-1-i) +: 16] = m_samples[idx];
    end
    return w;
  endfunction

  task automatic model_clear();
    m_samples.delete();
    m_phase   = 1'b0;
    m_held    = '0;
    m_overrun = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit v, input bit [7:0] b,
                            input bit bz);
    int n;
    m_next = 1'b0;
    if (r) begin
      model_clear();
      m_started = 1'b0;
    end else if (s) begin
      model_clear();
      m_started = 1'b1;
    end else if (m_started && v) begin
      if (!m_phase) begin
        m_held  = b;
        m_phase = 1'b1;
      end else begin
        m_samples.push_back({m_held, b});
        m_phase = 1'b0;
        n = m_samples.size();
        if (n >= int'(WL) && ((n - int'(WL)) % int'(ST)) == 0) begin
          if (bz) m_overrun = 1'b1;
          else    m_next = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v, input bit [7:0] b, input bit bz);
    rst = r; start = s; bif.i_byte_valid = v; bif.i_byte = b; busy = bz;
    @(posedge clk);
    model_edge(r, s, v, b, bz);
    #1;
    if (nxt === 1'b1) next_seen++;
    chk("window",  window,  model_window());
    chk("next",    WW'(nxt),     WW'(m_next));
    chk("filled",  WW'(filled),  WW'(m_samples.size() >= int'(WL)));
    chk("overrun", WW'(overrun), WW'(m_overrun));
    chk("ready",   WW'(bif.o_byte_ready), WW'(m_started));
  endtask

  task automatic send_pattern(input int first, input int last, input bit bz);
    for (int v = first; v <= last; v++) begin
      step(0, 0, 1, 8'h00, bz);
      step(0, 0, 1, 8'(v), bz);
    end
  endtask

  task automatic chk_ends(input string tag, input logic [15:0] s0, input logic [15:0] s39);
    chk({tag, "_s0"},  WW'(window[WW-1 -: 16]), WW'(s0));
    chk({tag, "_s39"}, WW'(window[15:0]),       WW'(s39));
  endtask

  initial begin
    bif.i_byte_valid = 1'b0;
    bif.i_byte = '0;
    m_started = 1'b0;
    model_clear();

    // Reset, then bytes without start are ignored
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 1, 8'h5a, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom), 0);

    // Fill: exactly one o_next, coincident with o_filled
    step(0, 1, 0, 8'h00, 0);
    next_seen = 0;
    send_pattern(1, 40, 0);
    chk("fill_nexts", WW'(next_seen), WW'(1));
    chk_ends("fill", 16'h0001, 16'h0028);

    // Stride: second o_next after the 8th new sample
    send_pattern(41, 48, 0);
    chk("stride_nexts", WW'(next_seen), WW'(2));
    chk_ends("stride", 16'h0009, 16'h0030);

    // Busy during an event sets sticky overrun; next free event still pulses
    send_pattern(49, 56, 1);
    chk("busy_nexts", WW'(next_seen), WW'(2));
    send_pattern(57, 64, 0);
    chk("after_busy_nexts", WW'(next_seen), WW'(3));
    chk("overrun_sticky", WW'(overrun), WW'(1));

    // Start with a byte pending after an odd count: byte dropped, next byte is high
    step(0, 0, 1, 8'hab, 0);
    step(0, 1, 1, 8'hcd, 0);
    chk("start_window", window, '0);
    step(0, 0, 1, 8'h12, 0);
    step(0, 0, 1, 8'h34, 0);
    chk("start_pair", WW'(window[15:0]), WW'(16'h1234));

    // Random traffic with occasional start/reset
    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 600) == 0, ($urandom % 200) == 0, ($urandom % 4) != 0,
           8'($urandom), ($urandom % 3) == 0);
    end

    // Reset in RUN mid-pair, then a fresh fill reproduces the first result
    step(0, 1, 0, 8'h00, 0);
    send_pattern(1, 45, 0);
    step(0, 0, 1, 8'h77, 0);
    step(1, 0, 1, 8'h88, 0);
    chk("rst_window", window, '0);
    chk("rst_ready", WW'(bif.o_byte_ready), WW'(0));
    step(0, 1, 0, 8'h00, 0);
    next_seen = 0;
    send_pattern(1, 40, 0);
    chk("refill_nexts", WW'(next_seen), WW'(1));
    chk_ends("refill", 16'h0001, 16'h0028);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
